// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings and defaults for the fetch/data memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_e;

    localparam int unsigned MAX_WAIT_DEFAULT = 4;
    localparam int unsigned STARVE_W         = 4;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// rtl/mem_arbiter_starve_cnt.sv - saturating count of fetch arbitration losses
module mem_arbiter_starve_cnt
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_limit
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(MAX_WAIT);

    logic [STARVE_W-1:0] r_cnt;

    // Clear dominates so a fetch win in the same cycle always restarts the count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt < LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_limit = (r_cnt >= LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one memory bus between fetch and data ports
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,

    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_be,
    input  logic                m_ready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    state_e              r_state;
    state_e              w_next;
    owner_e              r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_if_rvalid;
    logic                r_d_rvalid;

    logic                w_idle;
    logic                w_limit;
    logic                w_d_win;
    logic                w_f_win;
    logic                w_hs;
    logic                w_rsp;
    logic                w_inc;
    logic                w_clr;

    assign w_idle  = (r_state == ST_IDLE);
    assign w_d_win = w_idle && d_req && !w_limit;
    // Once the limit is hit a waiting fetch wins even against a pending data request
    assign w_f_win = w_idle && if_req && !(d_req && !w_limit);
    assign w_hs    = (r_state == ST_ISSUE) && m_ready;
    assign w_rsp   = (r_state == ST_RESP) && m_rvalid;
    assign w_inc   = w_d_win && if_req;
    assign w_clr   = w_f_win || (w_idle && !if_req);

    mem_arbiter_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_inc),
        .i_clr   (w_clr),
        .o_limit (w_limit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_d_win || w_f_win) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    w_next = r_we ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_rvalid) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        m_req     = (r_state == ST_ISSUE);
        m_we      = r_we;
        m_addr    = r_addr;
        m_wdata   = r_wdata;
        m_be      = r_be;
        if_gnt    = w_hs && (r_owner == OWN_FETCH);
        d_gnt     = w_hs && (r_owner == OWN_DATA);
        if_rvalid = r_if_rvalid;
        d_rvalid  = r_d_rvalid;
        if_rdata  = r_if_rdata;
        d_rdata   = r_d_rdata;
    end

    // Request fields are captured at arbitration so the bus stays stable even if a requester misbehaves
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_owner     <= OWN_FETCH;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            if (w_d_win) begin
                r_owner <= OWN_DATA;
                r_we    <= d_we;
                r_addr  <= d_addr;
                r_wdata <= d_wdata;
                r_be    <= d_we ? d_be : {BE_W{1'b1}};
            end else if (w_f_win) begin
                r_owner <= OWN_FETCH;
                r_we    <= 1'b0;
                r_addr  <= if_addr;
                r_wdata <= '0;
                r_be    <= {BE_W{1'b1}};
            end
            if (w_rsp) begin
                if (r_owner == OWN_DATA) begin
                    r_d_rdata  <= m_rdata;
                    r_d_rvalid <= 1'b1;
                end else begin
                    r_if_rdata  <= m_rdata;
                    r_if_rvalid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_ready = 1'b1;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_t;

    bus_t        exp_bus_f[$];
    bus_t        exp_bus_d[$];
    logic [31:0] exp_rsp_f[$];
    logic [31:0] exp_rsp_d[$];
    int          grant_log[$];
    bus_t        mon_e;
    logic [31:0] mon_r;
    int          checks = 0;
    int          errors = 0;
    int          rv_total = 0;
    int          rv0;
    logic [7:0]  ord;
    logic        rd_pend = 1'b0;
    logic [31:0] rd_data = '0;
    bit          rsp_hold = 1'b0;

    mem_arbiter #(.MAX_WAIT(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h00000013;
            32'h4:   return 32'h00100093;
            32'h8:   return 32'hCAFEF00D;
            default: return 32'h5A000000 | a;
        endcase
    endfunction

    always @(negedge clock) begin
        if (m_req && m_ready && !m_we) begin
            rd_pend = 1'b1;
            rd_data = rd_mem(m_addr);
        end
    end

    always @(posedge clock) begin
        #1;
        m_rvalid = 1'b0;
        if (rd_pend && !rsp_hold) begin
            m_rvalid = 1'b1;
            m_rdata  = rd_data;
            rd_pend  = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (m_req && m_ready) begin
            if (if_gnt == d_gnt) begin
                checks++; errors++;
                $display("FAIL gnt_onehot got if=%0b d=%0b want exactly one", if_gnt, d_gnt);
            end else if (d_gnt) begin
                grant_log.push_back(1);
                if (exp_bus_d.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_d got unexpected grant want none");
                end else begin
                    mon_e = exp_bus_d.pop_front();
                    chk("bus_d", {m_we, m_addr, m_wdata, m_be}, mon_e);
                end
            end else begin
                grant_log.push_back(0);
                if (exp_bus_f.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_f got unexpected grant want none");
                end else begin
                    mon_e = exp_bus_f.pop_front();
                    chk("bus_f", {m_we, m_addr, m_wdata, m_be}, mon_e);
                end
            end
        end else if (if_gnt || d_gnt) begin
            checks++; errors++;
            $display("FAIL gnt_no_handshake got if=%0b d=%0b want 0", if_gnt, d_gnt);
        end
        if (if_rvalid || d_rvalid) rv_total++;
        if (if_rvalid && d_rvalid) begin
            checks++; errors++;
            $display("FAIL rvalid_both got 11 want one");
        end else if (if_rvalid) begin
            if (exp_rsp_f.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_f got unexpected rvalid want none");
            end else begin
                mon_r = exp_rsp_f.pop_front();
                chk("rsp_f", if_rdata, mon_r);
            end
        end else if (d_rvalid) begin
            if (exp_rsp_d.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_d got unexpected rvalid want none");
            end else begin
                mon_r = exp_rsp_d.pop_front();
                chk("rsp_d", d_rdata, mon_r);
            end
        end
    end

    task automatic wait_gnt(input bit is_d);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(is_d ? d_gnt : if_gnt) && n < 60);
        if (!(is_d ? d_gnt : if_gnt)) begin
            checks++; errors++;
            $display("FAIL gnt_timeout got none want %s grant", is_d ? "data" : "fetch");
        end
    endtask

    task automatic fetch_req(input logic [31:0] a, input logic [31:0] exp_data);
        exp_bus_f.push_back({1'b0, a, 32'h0, 4'hF});
        exp_rsp_f.push_back(exp_data);
        if_req  = 1'b1;
        if_addr = a;
        wait_gnt(1'b0);
        @(posedge clock); #1;
        if_req = 1'b0;
    endtask

    task automatic data_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input bit want_rsp, input logic [31:0] exp_data);
        exp_bus_d.push_back({we, a, wd, we ? be : 4'hF});
        if (!we && want_rsp) exp_rsp_d.push_back(exp_data);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        wait_gnt(1'b1);
        @(posedge clock); #1;
        d_req = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset_outputs", {m_req, m_we, m_addr, m_wdata, m_be, if_gnt, d_gnt, if_rvalid, d_rvalid}, '0);
        chk("reset_rdata", {if_rdata, d_rdata}, '0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // fetch-only load with minimum latency
        exp_bus_f.push_back({1'b0, 32'h10, 32'h0, 4'hF});
        exp_rsp_f.push_back(32'h00000013);
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clock); chk("t1_c0_gnt", if_gnt, 1'b0);
        @(negedge clock); chk("t1_c1_gnt", {if_gnt, m_req, m_addr}, {1'b1, 1'b1, 32'h10});
        @(posedge clock); #1; if_req = 1'b0;
        @(negedge clock); chk("t1_c2_rvalid", if_rvalid, 1'b0);
        @(negedge clock); chk("t1_c3_rvalid", {if_rvalid, d_rvalid}, 2'b10);
        chk("t1_c3_rdata", if_rdata, 32'h00000013);

        // simultaneous: data store first, then fetch
        @(posedge clock); #1;
        grant_log.delete();
        fork
            fetch_req(32'h4, 32'h00100093);
            data_req(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
        join
        repeat (4) @(negedge clock);
        ord = '0;
        foreach (grant_log[i]) ord = {ord[6:0], grant_log[i][0]};
        chk("t2_order", {grant_log.size(), ord}, {32'd2, 8'b10});

        // starvation: four data wins, then fetch, then data again
        @(posedge clock); #1;
        grant_log.delete();
        fork
            fetch_req(32'h40, 32'h5A000040);
            begin
                data_req(1'b0, 32'h100, 32'h0, 4'h0, 1'b1, 32'h5A000100);
                data_req(1'b0, 32'h104, 32'h0, 4'h0, 1'b1, 32'h5A000104);
                data_req(1'b0, 32'h108, 32'h0, 4'h0, 1'b1, 32'h5A000108);
                data_req(1'b0, 32'h10C, 32'h0, 4'h0, 1'b1, 32'h5A00010C);
                data_req(1'b0, 32'h110, 32'h0, 4'h0, 1'b1, 32'h5A000110);
            end
        join
        repeat (4) @(negedge clock);
        ord = '0;
        foreach (grant_log[i]) ord = {ord[6:0], grant_log[i][0]};
        chk("t3_order", {grant_log.size(), ord}, {32'd6, 8'b00111101});
        chk("t3_starve_cnt", dut.u_starve.r_cnt, 4'd0);

        // bus backpressure on a data load
        @(posedge clock); #1;
        m_ready = 1'b0;
        fork
            data_req(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'hCAFEF00D);
            begin
                int n = 0;
                do begin
                    @(negedge clock);
                    n++;
                end while (!m_req && n < 20);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clock);
                    chk("t4_hold", {m_req, m_addr, m_be, d_gnt, if_gnt}, {1'b1, 32'h8, 4'hF, 1'b0, 1'b0});
                end
                @(posedge clock); #1;
                m_ready = 1'b1;
                @(negedge clock);
                chk("t4_gnt", d_gnt, 1'b1);
            end
        join
        repeat (3) @(negedge clock);

        // reset while waiting for read data
        @(posedge clock); #1;
        rsp_hold = 1'b1;
        data_req(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("t5_reset_outputs", {m_req, m_we, m_addr, m_wdata, m_be, if_gnt, d_gnt, if_rvalid, d_rvalid}, '0);
        chk("t5_reset_rdata", {if_rdata, d_rdata}, '0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        rsp_hold = 1'b0;
        rv0 = rv_total;
        repeat (5) @(negedge clock);
        chk("t5_no_stale", rv_total - rv0, 0);

        // partial-word store
        @(posedge clock); #1;
        rv0 = rv_total;
        data_req(1'b1, 32'h21, 32'h0000AB00, 4'h2, 1'b0, 32'h0);
        repeat (4) @(negedge clock);
        chk("t6_no_rvalid", rv_total - rv0, 0);

        chk("queues_empty", {exp_bus_f.size(), exp_bus_d.size(), exp_rsp_f.size(), exp_rsp_d.size()}, '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
